// File: rtl/clk_div_pkg.sv
`default_nettype none
`timescale 1ps/1ps
// =============================================================================
// clk_div_pkg : shared types and constants for the clock-divider controller
// Rev 1.0
// =============================================================================
package clk_div_pkg;

    localparam int RATIO_W = 6;

    localparam logic [RATIO_W-1:0] DEFAULT_RATIO = 6'd2;
    localparam int                 MIN_RATIO     = 2;

    typedef enum logic [2:0] {
        OFF    = 3'd0,
        SETTLE = 3'd1,
        RUN    = 3'd2,
        DRAIN  = 3'd3,
        GAP    = 3'd4
    } state_t;

    function automatic logic ratio_valid(input logic [RATIO_W-1:0] ratio,
                                         input logic [RATIO_W-1:0] min_ratio);
        return ratio >= min_ratio;
    endfunction

endpackage
`default_nettype wire

// File: rtl/clk_edge_sync.sv
`default_nettype none
`timescale 1ps/1ps
// =============================================================================
// clk_edge_sync : brings the divider output into reference_clk and flags edges
// Rev 1.0
// =============================================================================
module clk_edge_sync (
    input  logic reference_clk,
    input  logic reset,
    input  logic din,
    output logic rise,
    output logic fall
);

    logic meta;
    logic sync;
    logic prev;

    always_ff @(posedge reference_clk or negedge reset) begin
        if (!reset) begin
            meta <= 1'b0;
            sync <= 1'b0;
            prev <= 1'b0;
        end else begin
            meta <= din;
            sync <= meta;
            prev <= sync;
        end
    end

    // Pulses appear two cycles after the raw edge of din.
    assign rise = sync & ~prev;
    assign fall = ~sync & prev;

endmodule
`default_nettype wire

// File: rtl/clk_div_ctrl.sv
`default_nettype none
`timescale 1ps/1ps
// =============================================================================
// clk_div_ctrl : sequences glitch-safe ratio changes and enable of the divider
// Rev 1.0
// =============================================================================
module clk_div_ctrl #(
    parameter logic [clk_div_pkg::RATIO_W-1:0] DEFAULT_RATIO = clk_div_pkg::DEFAULT_RATIO,
    parameter int MIN_RATIO     = clk_div_pkg::MIN_RATIO,
    parameter int GAP_CYCLES    = 4,
    parameter int LOCK_EDGES    = 2,
    parameter int DRAIN_TIMEOUT = 128
) (
    input  logic                              reference_clk,
    input  logic                              reset,
    input  logic                              run_en,
    input  logic                              cfg_req,
    input  logic [clk_div_pkg::RATIO_W-1:0]   cfg_ratio,
    output logic                              cfg_ack,
    output logic                              cfg_err,
    input  logic                              div_output_clk,
    output logic                              clk_divider_enable,
    output logic [clk_div_pkg::RATIO_W-1:0]   division_ratio,
    output logic                              busy,
    output logic                              locked
);

    import clk_div_pkg::*;

    // GAP_CYCLES must be at least 2 so the load lands inside the gap;
    // DRAIN_TIMEOUT must fit the 8-bit cycle counter.
    localparam logic [RATIO_W-1:0] MIN_R      = RATIO_W'(MIN_RATIO);
    localparam logic [7:0]         DRAIN_LAST = 8'(DRAIN_TIMEOUT - 1);
    localparam logic [7:0]         GAP_LOAD   = 8'(GAP_CYCLES - 2);
    localparam logic [7:0]         GAP_LAST   = 8'(GAP_CYCLES - 1);
    localparam logic [2:0]         LOCK_LAST  = 3'(LOCK_EDGES - 1);

    state_t             state;
    state_t             state_nx;
    logic [7:0]         cyc_cnt;
    logic [2:0]         edge_cnt;
    logic [RATIO_W-1:0] pending;
    logic               load_pend;
    logic               fb_rise;
    logic               fb_fall;
    logic               sample;
    logic               req_ok;
    logic               enter;

    clk_edge_sync u_edge_sync (
        .reference_clk (reference_clk),
        .reset         (reset),
        .din           (div_output_clk),
        .rise          (fb_rise),
        .fall          (fb_fall)
    );

    // A request still high during its own ack/err cycle must not be taken twice.
    assign sample = ((state == OFF) || (state == RUN)) && cfg_req && !cfg_ack && !cfg_err;
    assign req_ok = ratio_valid(cfg_ratio, MIN_R);
    assign enter  = (state_nx != state);

    always_comb begin
        state_nx = state;
        case (state)
            OFF: begin
                if (!sample && run_en) begin
                    state_nx = SETTLE;
                end
            end
            SETTLE: begin
                if (!run_en) begin
                    state_nx = OFF;
                end else if (fb_rise && (edge_cnt >= LOCK_LAST)) begin
                    state_nx = RUN;
                end
            end
            RUN: begin
                if (sample) begin
                    if (req_ok) begin
                        state_nx = DRAIN;
                    end
                end else if (!run_en) begin
                    state_nx = DRAIN;
                end
            end
            DRAIN: begin
                if (fb_fall || (cyc_cnt >= DRAIN_LAST)) begin
                    state_nx = GAP;
                end
            end
            GAP: begin
                if (cyc_cnt >= GAP_LAST) begin
                    state_nx = run_en ? SETTLE : OFF;
                end
            end
            default: begin
                state_nx = OFF;
            end
        endcase
    end

    always_ff @(posedge reference_clk or negedge reset) begin
        if (!reset) begin
            state              <= OFF;
            clk_divider_enable <= 1'b0;
            busy               <= 1'b0;
            locked             <= 1'b0;
        end else begin
            state              <= state_nx;
            clk_divider_enable <= (state_nx == SETTLE) || (state_nx == RUN) ||
                                  (state_nx == DRAIN);
            busy               <= (state_nx == SETTLE) || (state_nx == DRAIN) ||
                                  (state_nx == GAP);
            locked             <= (state_nx == RUN);
        end
    end

    always_ff @(posedge reference_clk or negedge reset) begin
        if (!reset) begin
            cfg_ack <= 1'b0;
            cfg_err <= 1'b0;
        end else begin
            cfg_ack <= sample && req_ok;
            cfg_err <= sample && !req_ok;
        end
    end

    always_ff @(posedge reference_clk or negedge reset) begin
        if (!reset) begin
            cyc_cnt  <= 8'd0;
            edge_cnt <= 3'd0;
        end else begin
            if (enter) begin
                cyc_cnt <= 8'd0;
            end else if (cyc_cnt != 8'hFF) begin
                cyc_cnt <= cyc_cnt + 8'd1;
            end

            if (enter) begin
                edge_cnt <= 3'd0;
            end else if (fb_rise && (edge_cnt != 3'd7)) begin
                edge_cnt <= edge_cnt + 3'd1;
            end
        end
    end

    // Ratio moves only with the divider disabled: directly in OFF, or one
    // cycle before the end of the gap so it is stable before re-enable.
    always_ff @(posedge reference_clk or negedge reset) begin
        if (!reset) begin
            pending        <= DEFAULT_RATIO;
            load_pend      <= 1'b0;
            division_ratio <= DEFAULT_RATIO;
        end else begin
            if ((state == RUN) && sample && req_ok) begin
                pending   <= cfg_ratio;
                load_pend <= 1'b1;
            end else if ((state == GAP) && enter) begin
                load_pend <= 1'b0;
            end

            if ((state == OFF) && sample && req_ok) begin
                division_ratio <= cfg_ratio;
            end else if ((state == GAP) && load_pend && (cyc_cnt == GAP_LOAD)) begin
                division_ratio <= pending;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_clk_div_ctrl.sv
`default_nettype none
`timescale 1ps/1ps
// =============================================================================
// tb_clk_div_ctrl : directed and randomized checks of clk_div_ctrl with a divider
// Rev 1.0
// =============================================================================
module tb_clk_div_ctrl;

    localparam int GAP_CYCLES = 4;
    localparam int MIN_RATIO  = 2;
    localparam int BUDGET     = 800;

    logic       reference_clk = 1'b0;
    logic       reset         = 1'b0;
    logic       run_en        = 1'b0;
    logic       cfg_req       = 1'b0;
    logic [5:0] cfg_ratio     = 6'd0;
    logic       cfg_ack;
    logic       cfg_err;
    logic       clk_divider_enable;
    logic [5:0] division_ratio;
    logic       busy;
    logic       locked;
    logic       output_clk;
    logic [5:0] dcnt;

    int tests = 0;
    int fails = 0;

    always #20 reference_clk = ~reference_clk;

    clk_div_ctrl #(
        .DEFAULT_RATIO (6'd2),
        .MIN_RATIO     (MIN_RATIO),
        .GAP_CYCLES    (GAP_CYCLES),
        .LOCK_EDGES    (2),
        .DRAIN_TIMEOUT (128)
    ) dut (
        .reference_clk      (reference_clk),
        .reset              (reset),
        .run_en             (run_en),
        .cfg_req            (cfg_req),
        .cfg_ratio          (cfg_ratio),
        .cfg_ack            (cfg_ack),
        .cfg_err            (cfg_err),
        .div_output_clk     (output_clk),
        .clk_divider_enable (clk_divider_enable),
        .division_ratio     (division_ratio),
        .busy               (busy),
        .locked             (locked)
    );

    // Behavioural divider: period = ratio cycles, held low while disabled.
    always @(posedge reference_clk or negedge reset) begin
        if (!reset) begin
            dcnt       <= 6'd0;
            output_clk <= 1'b0;
        end else if (!clk_divider_enable) begin
            dcnt       <= 6'd0;
            output_clk <= 1'b0;
        end else begin
            output_clk <= (dcnt < (division_ratio >> 1));
            dcnt       <= (dcnt >= division_ratio - 6'd1) ? 6'd0 : dcnt + 6'd1;
        end
    end

    // Observers: pulse counts, enable-low run length and where the ratio moved in it.
    int         ack_cnt = 0;
    int         err_cnt = 0;
    int         illegal = 0;
    int         low_run = 0;
    int         chg_idx = 0;
    int         gap_len = 0;
    int         gap_chg = 0;
    logic       prev_en = 1'b0;
    logic [5:0] prev_ratio = 6'd2;

    always @(negedge reference_clk) begin
        if (reset) begin
            if (cfg_ack) ack_cnt++;
            if (cfg_err) err_cnt++;
            if ((division_ratio != prev_ratio) && (clk_divider_enable || prev_en)) illegal++;
            if (!clk_divider_enable) begin
                if (prev_en) begin
                    low_run = 1;
                    chg_idx = 0;
                end else begin
                    low_run++;
                end
                if (division_ratio != prev_ratio) chg_idx = low_run;
            end else if (!prev_en) begin
                gap_len = low_run;
                gap_chg = chg_idx;
            end
        end
        prev_en    = clk_divider_enable;
        prev_ratio = division_ratio;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(negedge reference_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic do_req(input logic [5:0] r, output logic a, output logic e,
                          output logic [5:0] rat_at_resp);
        int n = 0;
        cfg_ratio = r;
        cfg_req   = 1'b1;
        while (!cfg_ack && !cfg_err && n < BUDGET) begin
            step();
            n++;
        end
        a           = cfg_ack;
        e           = cfg_err;
        rat_at_resp = division_ratio;
        chk("req_response_in_budget", 32'(n < BUDGET), 1);
        @(posedge reference_clk);
        #1;
        cfg_req = 1'b0;
    endtask

    task automatic wait_locked(input string tag);
        int n = 0;
        while (!locked && n < BUDGET) begin
            step();
            n++;
        end
        chk(tag, 32'(locked), 1);
    endtask

    task automatic measure_period(input string tag, input int exp);
        int   n  = 0;
        int   t1 = -1;
        int   t2 = -1;
        logic p  = output_clk;
        while (t2 < 0 && n < 300) begin
            step();
            n++;
            if (output_clk && !p) begin
                if (t1 < 0) t1 = n;
                else        t2 = n;
            end
            p = output_clk;
        end
        chk(tag, 32'(t2 - t1), 32'(exp));
    endtask

    initial begin
        logic       a;
        logic       e;
        logic [5:0] rat;
        logic [5:0] r;
        logic [5:0] exp_ratio;
        int         base_ack;
        int         base_err;
        int         n;

        // Reset with run requested
        run_en = 1'b1;
        step();
        step();
        chk("rst_enable", 32'(clk_divider_enable), 0);
        chk("rst_ratio",  32'(division_ratio), 2);
        chk("rst_locked", 32'(locked), 0);
        chk("rst_busy",   32'(busy), 0);
        chk("rst_ack_err", 32'({cfg_ack, cfg_err}), 0);
        reset = 1'b1;
        step();
        chk("settle_busy",   32'(busy), 1);
        chk("settle_enable", 32'(clk_divider_enable), 1);
        wait_locked("lock_initial");
        chk("ratio_initial", 32'(division_ratio), 2);
        measure_period("period_2", 2);
        exp_ratio = 6'd2;

        // Change to 5 from RUN
        base_ack = ack_cnt;
        do_req(6'd5, a, e, rat);
        chk("req5_ack", 32'({a, e}), 32'b10);
        wait_locked("lock_5");
        chk("ratio_5", 32'(division_ratio), 5);
        chk("req5_single_ack", 32'(ack_cnt - base_ack), 1);
        chk("gap_len_5", 32'(gap_len), GAP_CYCLES);
        chk("gap_load_last_5", 32'(gap_chg), GAP_CYCLES);
        measure_period("period_5", 5);
        exp_ratio = 6'd5;

        // Rejected ratios
        for (int i = 0; i < 2; i++) begin
            r = (i == 0) ? 6'd1 : 6'd0;
            base_ack = ack_cnt;
            base_err = err_cnt;
            do_req(r, a, e, rat);
            chk("bad_req_resp", 32'({a, e}), 32'b01);
            step();
            chk("bad_req_ratio", 32'(division_ratio), 32'(exp_ratio));
            chk("bad_req_locked", 32'(locked), 1);
            chk("bad_req_counts", 32'({8'(ack_cnt - base_ack), 8'(err_cnt - base_err)}), 32'h0001);
        end

        // Back-to-back: 8 is held while the change to 3 is in progress
        base_ack = ack_cnt;
        do_req(6'd3, a, e, rat);
        chk("b2b_3_ack", 32'(a), 1);
        step();
        cfg_ratio = 6'd8;
        cfg_req   = 1'b1;
        wait_locked("lock_3");
        chk("ratio_3", 32'(division_ratio), 3);
        chk("b2b_no_early_ack", 32'(ack_cnt - base_ack), 1);
        do_req(6'd8, a, e, rat);
        chk("b2b_8_ack", 32'(a), 1);
        wait_locked("lock_8");
        chk("ratio_8", 32'(division_ratio), 8);
        measure_period("period_8", 8);
        exp_ratio = 6'd8;

        // Randomized requests against the accept/reject rule
        for (int i = 0; i < 5; i++) begin
            r = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(0, 1)) : 6'($urandom_range(2, 63));
            do_req(r, a, e, rat);
            if (int'(r) >= MIN_RATIO) begin
                chk("rnd_ack", 32'({a, e}), 32'b10);
                exp_ratio = r;
                wait_locked("rnd_lock");
                chk("rnd_gap_len", 32'(gap_len), GAP_CYCLES);
                chk("rnd_gap_load_last", 32'(gap_chg), GAP_CYCLES);
            end else begin
                chk("rnd_err", 32'({a, e}), 32'b01);
                step();
                chk("rnd_locked_kept", 32'(locked), 1);
            end
            chk("rnd_ratio", 32'(division_ratio), 32'(exp_ratio));
            measure_period("rnd_period", int'(exp_ratio));
        end

        // Stop: drain and gap, then OFF
        run_en = 1'b0;
        n = 0;
        while ((busy || locked || clk_divider_enable) && n < BUDGET) begin
            step();
            n++;
        end
        chk("stop_enable", 32'(clk_divider_enable), 0);
        chk("stop_idle",   32'({busy, locked}), 0);
        chk("stop_ratio",  32'(division_ratio), 32'(exp_ratio));

        // Load in OFF takes effect in the ack cycle
        do_req(6'd6, a, e, rat);
        chk("off_ack", 32'(a), 1);
        chk("off_ratio_at_ack", 32'(rat), 6);
        step();
        step();
        chk("off_stays_off", 32'({clk_divider_enable, busy, locked}), 0);
        run_en = 1'b1;
        wait_locked("lock_6");
        chk("ratio_6", 32'(division_ratio), 6);
        measure_period("period_6", 6);

        // Reset in GAP with 8 pending
        do_req(6'd8, a, e, rat);
        chk("gap_req_ack", 32'(a), 1);
        n = 0;
        while (!(busy && !clk_divider_enable) && n < BUDGET) begin
            step();
            n++;
        end
        chk("reach_gap", 32'(busy && !clk_divider_enable), 1);
        reset = 1'b0;
        #1;
        chk("mid_rst_enable", 32'(clk_divider_enable), 0);
        chk("mid_rst_ratio",  32'(division_ratio), 2);
        chk("mid_rst_flags",  32'({busy, locked, cfg_ack, cfg_err}), 0);
        step();
        step();
        reset = 1'b1;
        step();
        chk("post_rst_ratio", 32'(division_ratio), 2);
        wait_locked("lock_post_rst");
        chk("post_rst_lock_ratio", 32'(division_ratio), 2);
        measure_period("period_post_rst", 2);

        chk("no_ratio_change_while_enabled", 32'(illegal), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
